spi_target_ctrl: RTL
====================

// Module: spi_target_ctrl
// PURPOSE
//  SPI target (responder), mode 0, MSB first: the far end of spi_ctrl, which lets one tinyQV act as
//  SPI peripheral to another controller. Oversamples external CS/SCK/MOSI in clk, shifts received bytes into
//  an RX FIFO and returns a CPU-loaded TX byte on MISO. Sits behind two peripheral slots (data, status) in the top level.
// PARAMETERS
//  RX_DEPTH     4    RX FIFO entries; power of 2, >=2
//  SYNC_STAGES  2    flops per input synchroniser (2 or 3)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active high
//  spi_cs_n      in   1  target select from controller, active low, async
//  spi_sck       in   1  SPI clock from controller, async
//  spi_mosi      in   1  data from controller, async
//  spi_dc_in     in   1  D/C from controller (present only with SPI_TARGET_DC_EN)
//  spi_miso      out  1  data to controller
//  spi_miso_oe   out  1  MISO drive enable; 1 only while synchronised CS is low
//  tx_data       in   8  byte to return in next transfer
//  tx_load       in   1  1-cycle strobe: tx_data -> TX holding reg
//  tx_empty      out  1  holding reg consumed / never loaded
//  rx_read       in   1  1-cycle strobe: pop RX FIFO head
//  rx_valid      out  1  RX FIFO not empty
//  rx_data       out  8  FIFO head byte (0x00 when empty)
//  rx_dc         out  1  D/C captured with head byte (0 when macro off)
//  rx_overrun    out  1  sticky: byte dropped because FIFO full
//  clr_overrun   in   1  1-cycle strobe: clear rx_overrun
//  busy          out  1  transfer in progress (synchronised CS low)
// BEHAVIOUR
//  Reset: spi_miso=1, spi_miso_oe=0, tx_empty=1, rx_valid=0, rx_data=0, rx_dc=0, rx_overrun=0, busy=0; FIFO cleared.
//  Inputs pass SYNC_STAGES flops; edges detected on synced SCK/CS. SCK high and low phases >= 3 clk each.
//  FSM IDLE: on synced CS falling -> SHIFT; shift reg <= holding (tx_empty ? 8'hFF : holding), tx_empty<=1,
//    bit_cnt<=0. MISO = shift[7] from the same cycle; oe=1.
//  SHIFT: SCK rising -> rx_shift <= {rx_shift[6:0], mosi}, bit_cnt++ (3-bit wrap). SCK falling -> tx shift left by 1.
//    When bit_cnt wraps 7->0 on a rising edge: push {dc, byte} to FIFO in that cycle; tx shift reg reloads from
//    holding (0xFF if empty) on the following falling edge, tx_empty<=1 then.
//  CS rising (any state) -> IDLE next cycle; partial byte (bit_cnt!=0) discarded, no push; oe=0, miso=1.
//  CS rising coincident with 8th SCK rising: the push still happens.
//  tx_load: holding<=tx_data, tx_empty<=0; tx_load in same cycle as a reload: reload takes the NEW tx_data, tx_empty stays 1.
//  FIFO full + push w/o rx_read: byte dropped, rx_overrun<=1. Full + push + rx_read same cycle: both occur, no overrun.
//  rx_read when empty: ignored. clr_overrun with new overrun same cycle: overrun wins (stays 1).
//  Push-to-rx_valid latency: 1 clk after push cycle; rx_data/rx_dc registered FIFO head.
//  Reset asserted mid-transfer: everything returns to reset values; the in-flight byte is lost.
// CONFIGURATION
//  SPI_TARGET_DC_EN defined: spi_dc_in port exists, synchronised, sampled on each byte's 8th SCK rising edge and
//    stored as FIFO bit 8; rx_dc outputs it.
//  Not defined: no spi_dc_in port, FIFO 8 bits wide, rx_dc tied 0.
// STRUCTURE
//  Package spi_target_pkg: FSM state enum (ST_IDLE, ST_SHIFT), TX_IDLE_BYTE=8'hFF, FIFO_W.
//  Sub-module spi_target_fifo (RX_DEPTH x FIFO_W, registered head, full/empty, simultaneous push/pop).
//  Synchronisers inline; top-level wiring to PERI slots is out of scope.
// TESTING
//  1 Load 0xA5, controller sends 0x3C (sck=clk/8) -> rx_data=0x3C, rx_valid=1, MISO bits 1,0,1,0,0,1,0,1, tx_empty=1.
//  2 No tx_load, controller sends 2 bytes in one CS -> MISO returns 0xFF,0xFF; FIFO holds both in order.
//  3 Send 5 bytes, no reads (RX_DEPTH=4) -> first 4 kept, 5th dropped, rx_overrun=1; clr_overrun -> 0.
//  4 CS released after 5 bits, then full byte 0x81 -> only 0x81 in FIFO, rx_valid set once.
//  5 FIFO full, rx_read on push cycle -> no overrun, order preserved; rst mid-byte -> all outputs at reset values.
//  6 SPI_TARGET_DC_EN: dc=1 during 0x55, dc=0 during 0xAA -> rx_dc 1 then 0 with respective bytes.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target (mode 0, MSB first).
// SPI_TARGET_DC_EN widens the RX FIFO by one bit to carry the D/C flag.
package spi_target_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

`ifdef SPI_TARGET_DC_EN
  localparam int FIFO_W = 9;
`else
  localparam int FIFO_W = 8;
`endif

endpackage

// File: rtl/spi_target_fifo.sv
// RX FIFO with a registered head word (zero when empty); push and pop may share a cycle,
// including when full, where the popped slot is reused by the incoming word.
module spi_target_fifo
  import spi_target_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FIFO_W-1:0] din,
  input  logic              pop,
  output logic [FIFO_W-1:0] head,
  output logic              not_empty,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0]     count, count_nx;
  logic              empty, full, do_push, do_pop;
  logic [FIFO_W-1:0] head_nx;

  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    overflow  = push && full && !do_pop;
    rd_ptr_nx = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nx  = count + CW'(do_push) - CW'(do_pop);
    head_nx   = '0;
    // The next head is the word being written only when it lands in the slot the read pointer moves to.
    if (count_nx != '0)
      head_nx = (do_push && (rd_ptr_nx == wr_ptr)) ? din : mem[rd_ptr_nx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
      head   <= head_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign not_empty = !empty;

endmodule

// File: rtl/spi_target_ctrl.sv
// SPI target, mode 0, MSB first: oversampled CS/SCK/MOSI, RX FIFO, single TX holding byte.
// Define SPI_TARGET_DC_EN to add spi_dc_in, captured with each byte and returned on rx_dc.
module spi_target_ctrl
  import spi_target_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
`ifdef SPI_TARGET_DC_EN
  input  logic       spi_dc_in,
`endif
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  input  logic       rx_read,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_overrun,
  input  logic       clr_overrun,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_prev, sck_prev;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;

  state_t            state, state_nx;
  logic [2:0]        bit_cnt;
  logic              reload_pend;
  logic [7:0]        hold, tx_shift, load_byte, rx_byte;
  logic [6:0]        rx_shift;
  logic              start, active, bit_rise, byte_done, reload;
  logic              push, overflow;
  logic [FIFO_W-1:0] fifo_din, fifo_head;

  // CS resets high and SCK low so no false edge appears when reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
    end
  end

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (cs_fall) state_nx = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    start     = (state == ST_IDLE) && cs_fall;
    active    = (state == ST_SHIFT);
    bit_rise  = active && sck_rise;
    byte_done = bit_rise && (bit_cnt == 3'd7);
    reload    = start || (active && sck_fall && reload_pend);
    // A tx_load landing on a reload goes straight into the shifter.
    load_byte = tx_load ? tx_data : (tx_empty ? TX_IDLE_BYTE : hold);
    rx_byte   = {rx_shift, mosi_s};
    push      = byte_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_empty    <= 1'b1;
      bit_cnt     <= 3'd0;
      reload_pend <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (reload)       tx_empty <= 1'b1;
      else if (tx_load) tx_empty <= 1'b0;
      if (start) begin
        bit_cnt     <= 3'd0;
        reload_pend <= 1'b0;
      end else if (bit_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) reload_pend <= 1'b1;
      end else if (reload) begin
        reload_pend <= 1'b0;
      end
      if (overflow)         rx_overrun <= 1'b1;
      else if (clr_overrun) rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load) hold <= tx_data;
    if (reload)                    tx_shift <= load_byte;
    else if (active && sck_fall)   tx_shift <= {tx_shift[6:0], 1'b1};
    if (bit_rise) rx_shift <= rx_byte[6:0];
  end

  // On the selecting cycle the shifter is still loading, so present its bit 7 directly.
  assign spi_miso_oe = ~cs_s;
  assign busy        = ~cs_s;
  assign spi_miso    = cs_s ? 1'b1 : (start ? load_byte[7] : tx_shift[7]);

`ifdef SPI_TARGET_DC_EN
  logic [SYNC_STAGES-1:0] dc_sync;

  always_ff @(posedge clk) begin
    dc_sync <= {dc_sync[SYNC_STAGES-2:0], spi_dc_in};
  end

  assign fifo_din = {dc_sync[SYNC_STAGES-1], rx_byte};
  assign rx_dc    = fifo_head[8];
`else
  assign fifo_din = rx_byte;
  assign rx_dc    = 1'b0;
`endif

  assign rx_data = fifo_head[7:0];

  spi_target_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (fifo_din),
    .pop      (rx_read),
    .head     (fifo_head),
    .not_empty(rx_valid),
    .overflow (overflow)
  );

endmodule
